// File: rtl/cpu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_seq_ctrl
//
// Multi-cycle sequencer for the 16-bit CPU. Each instruction walks through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and then returns to FETCH. The block
// consumes the opcode decoder's static control flags and the ALU zero flag. It
// produces the PC, IR, MDR, register-file and memory strobes for the datapath.
//
// Parameters
//   MEM_TIMEOUT  consecutive not-ready cycles with mem_req high before FAULT
//                (0 disables the timeout)
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   dec_*           static decoder flags for the instruction held in IR
//   alu_zero        ALU result == 0, meaningful in EXEC
//   mem_ready       memory accepts/completes the current request this cycle
//   mem_req/mem_we  memory request and write qualifier
//   mem_sel         address mux: 0 = PC (fetch), 1 = ALU result (data)
//   ir_load         capture memory read data into IR
//   mdr_load        capture memory read data into MDR
//   rf_we           register-file write enable
//   pc_en, pc_src   PC update (marks retire) and PC source (1 = branch target)
//   halted, fault   sticky HALT / memory-timeout indications
//   state           current sequencer state (debug visibility)
//   instr_count     retired-instruction counter, wraps at all-ones
//
// Memory handshake (req/ready):
//   mem_req is a pure decode of the FETCH/MEM states. A transfer takes place
//   in every cycle where mem_req and mem_ready are both high, and the FSM
//   leaves the access state on that same edge. While mem_ready is low the
//   request is held unchanged (same mem_sel/mem_we). The only ways to drop an
//   outstanding request without a transfer are rst and the wait timeout.
// -----------------------------------------------------------------------------
module cpu_seq_ctrl #(
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_reg_write,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    input  logic             dec_branch,
    input  logic             dec_branch_ne,
    input  logic             dec_pc_write,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             ir_load,
    output logic             mdr_load,
    output logic             rf_we,
    output logic             pc_en,
    output logic             pc_src,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    // -------------------------------------------------------------------------
    // State encoding is visible on the state port, so the values are fixed.
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    // -------------------------------------------------------------------------
    // Wait counter sizing. The counter never has to hold more than
    // MEM_TIMEOUT-1: on the not-ready cycle at that value the FSM moves to
    // FAULT, and the state change clears the counter.
    // -------------------------------------------------------------------------
    localparam int WAIT_W = (MEM_TIMEOUT <= 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam bit TIMEOUT_ON = (MEM_TIMEOUT > 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    state_t             state_q;
    state_t             state_d;
    logic [WAIT_W-1:0]  wait_q;
    logic [WAIT_W-1:0]  wait_d;
    logic [CNT_W-1:0]   count_q;

    // Decoded helpers, meaningful only in the states that sample them.
    logic is_mem_op;
    logic branch_taken;
    logic timeout_hit;

    assign is_mem_op    = dec_mem_read | dec_mem_write;
    assign branch_taken = (dec_branch & alu_zero) | (dec_branch_ne & ~alu_zero);

    // A not-ready cycle at the last allowed count ends the wait. A ready in the
    // same cycle wins, because the transfer happens and the count is cleared.
    assign timeout_hit  = TIMEOUT_ON && !mem_ready && (wait_q == WAIT_LAST);

    // -------------------------------------------------------------------------
    // State, wait counter and retire counter registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            // pc_en is the retire strobe. The counter wraps naturally.
            if (pc_en) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state, outputs and wait-counter update.
    // Outputs are decodes of the current state, qualified by mem_ready, the
    // decoder flags and alu_zero only where the state needs them. That way a
    // flag change in FETCH, WB, HALT or FAULT cannot affect anything.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_sel  = 1'b0;
        ir_load  = 1'b0;
        mdr_load = 1'b0;
        rf_we    = 1'b0;
        pc_en    = 1'b0;
        pc_src   = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                mem_sel = 1'b0;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end

            S_DECODE: begin
                // dec_pc_write=0 identifies the HALT opcode.
                state_d = dec_pc_write ? S_EXEC : S_HALT;
            end

            S_EXEC: begin
                if (is_mem_op) begin
                    state_d = S_MEM;
                end else if (dec_reg_write) begin
                    state_d = S_WB;
                end else begin
                    // Branches and flag-less opcodes retire here.
                    pc_en   = 1'b1;
                    pc_src  = branch_taken;
                    state_d = S_FETCH;
                end
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                // A load takes precedence when both flags are set, so a
                // write is only requested for a pure store.
                mem_we  = dec_mem_write & ~dec_mem_read;
                if (mem_ready) begin
                    if (dec_mem_read) begin
                        mdr_load = 1'b1;
                        state_d  = S_WB;
                    end else begin
                        pc_en    = 1'b1;
                        pc_src   = 1'b0;
                        state_d  = S_FETCH;
                    end
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end

            S_WB: begin
                rf_we   = 1'b1;
                pc_en   = 1'b1;
                pc_src  = 1'b0;
                state_d = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            S_FAULT: begin
                fault = 1'b1;
            end

            default: begin
                // Unused encoding 7: restart the instruction stream cleanly.
                state_d = S_FETCH;
            end
        endcase

        // The wait counter only advances while a request is stalled. Any
        // accepted transfer or any state change restarts it from zero.
        if (mem_ready || (state_d != state_q)) begin
            wait_d = '0;
        end else if (TIMEOUT_ON && ((state_q == S_FETCH) || (state_q == S_MEM))) begin
            wait_d = wait_q + WAIT_W'(1);
        end

        // While reset is held, every strobe is quiet. This drops any access
        // in flight and prevents a partial retire or register write.
        if (rst) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            mem_sel  = 1'b0;
            ir_load  = 1'b0;
            mdr_load = 1'b0;
            rf_we    = 1'b0;
            pc_en    = 1'b0;
            pc_src   = 1'b0;
            halted   = 1'b0;
            fault    = 1'b0;
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule
